// File: rtl/des_key_sched.sv
// DES key schedule: produces the sixteen 48-bit round subkeys in encrypt or decrypt order
// behind a valid/ready handshake. DES bit n of a W-bit vector lives at index [W-n].

module des_pc2 (
    input  logic [27:0] c,
    input  logic [27:0] d,
    output logic [47:0] k
);

    // Eight bits of C||D (9,18,22,25,35,38,43,54) are dropped by PC2 by design.
    logic unused_dropped;
    assign unused_dropped = ^{c[28-9], c[28-18], c[28-22], c[28-25],
                              d[28-7], d[28-10], d[28-15], d[28-26]};

    assign k = {c[28-14], c[28-17], c[28-11], c[28-24], c[28-1],  c[28-5],
                c[28-3],  c[28-28], c[28-15], c[28-6],  c[28-21], c[28-10],
                c[28-23], c[28-19], c[28-12], c[28-4],  c[28-26], c[28-8],
                c[28-16], c[28-7],  c[28-27], c[28-20], c[28-13], c[28-2],
                d[28-13], d[28-24], d[28-3],  d[28-9],  d[28-19], d[28-27],
                d[28-2],  d[28-12], d[28-23], d[28-17], d[28-5],  d[28-20],
                d[28-16], d[28-21], d[28-11], d[28-28], d[28-6],  d[28-25],
                d[28-18], d[28-14], d[28-22], d[28-8],  d[28-1],  d[28-4]};

endmodule

module des_key_sched (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        decrypt,
    input  logic [63:0] key,
    input  logic        subkey_ready,
    output logic [47:0] subkey,
    output logic        subkey_valid,
    output logic [3:0]  round,
    output logic        busy,
    output logic        done
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]  state_q;
    logic [27:0] c_q, d_q;
    logic [3:0]  round_q;
    logic        mode_q;
    logic        done_q;

    logic [27:0] pc1_c, pc1_d;
    logic [27:0] nxt_c, nxt_d;
    logic [3:0]  nxt_round;
    logic        shift_two;

    // Parity bits 8,16,...,64 take no part in the schedule.
    logic unused_parity;
    assign unused_parity = ^{key[56], key[48], key[40], key[32],
                             key[24], key[16], key[8],  key[0]};

    assign pc1_c = {key[64-57], key[64-49], key[64-41], key[64-33], key[64-25], key[64-17],
                    key[64-9],  key[64-1],  key[64-58], key[64-50], key[64-42], key[64-34],
                    key[64-26], key[64-18], key[64-10], key[64-2],  key[64-59], key[64-51],
                    key[64-43], key[64-35], key[64-27], key[64-19], key[64-11], key[64-3],
                    key[64-60], key[64-52], key[64-44], key[64-36]};
    assign pc1_d = {key[64-63], key[64-55], key[64-47], key[64-39], key[64-31], key[64-23],
                    key[64-15], key[64-7],  key[64-62], key[64-54], key[64-46], key[64-38],
                    key[64-30], key[64-22], key[64-14], key[64-6],  key[64-61], key[64-53],
                    key[64-45], key[64-37], key[64-29], key[64-21], key[64-13], key[64-5],
                    key[64-28], key[64-20], key[64-12], key[64-4]};

    function automatic logic [27:0] rotl(input logic [27:0] v, input logic two);
        return two ? {v[25:0], v[27:26]} : {v[26:0], v[27]};
    endfunction

    function automatic logic [27:0] rotr(input logic [27:0] v, input logic two);
        return two ? {v[1:0], v[27:2]} : {v[0], v[27:1]};
    endfunction

    // Rounds 2, 9 and 16 move by one position in both directions; all others by two.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        nxt_c     = c_q;
        nxt_d     = d_q;
        nxt_round = round_q + 4'd1;
        shift_two = !(nxt_round == 4'd1 || nxt_round == 4'd8 || nxt_round == 4'd15);
        if (mode_q) begin
            nxt_c = rotr(c_q, shift_two);
            nxt_d = rotr(d_q, shift_two);
        end else begin
            nxt_c = rotl(c_q, shift_two);
            nxt_d = rotl(d_q, shift_two);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) begin
            state_q <= S_IDLE;
            c_q     <= '0;
            d_q     <= '0;
            round_q <= '0;
            mode_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        c_q     <= decrypt ? pc1_c : rotl(pc1_c, 1'b0);
                        d_q     <= decrypt ? pc1_d : rotl(pc1_d, 1'b0);
                        mode_q  <= decrypt;
                        round_q <= 4'd0;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    // start is deliberately not looked at here, including on the final transfer.
                    if (subkey_ready) begin
                        if (round_q == 4'd15) begin
                            state_q <= S_IDLE;
                            done_q  <= 1'b1;
                        end else begin
                            c_q     <= nxt_c;
                            d_q     <= nxt_d;
                            round_q <= nxt_round;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    des_pc2 u_pc2 (
        .c (c_q),
        .d (d_q),
        .k (subkey)
    );

    assign subkey_valid = (state_q == S_RUN);
    assign busy         = (state_q == S_RUN);
    assign round        = round_q;
    assign done         = done_q;

endmodule

// File: doc/des_key_sched.md
DES_KEY_SCHED -- requirements
Module: des_key_sched

Interface
REQ-001 The module SHALL have no parameters; all widths are fixed by DES.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request to begin a 16-round subkey sequence.
REQ-005 decrypt  input  1  0 = encrypt order K1..K16, 1 = decrypt order K16..K1; sampled with start.
REQ-006 key  input  [1:64]  DES key, bit 1 = MSB, parity bits 8,16,...,64 ignored; sampled with start.
REQ-007 subkey_ready  input  1  downstream round datapath accepts current subkey.
REQ-008 subkey  output  [1:48]  current 48-bit round subkey, DES bit numbering.
REQ-009 subkey_valid  output  1  subkey is valid for the round shown on round.
REQ-010 round  output  [3:0]  current round index, 1..16 encoded as 0..15.
REQ-011 busy  output  1  high from start acceptance until the last subkey is accepted.
REQ-012 done  output  1  one-cycle pulse after the 16th subkey is accepted.

Function
REQ-013 Internal state SHALL be two 28-bit registers C, D, a 4-bit round counter, a mode bit, and FSM states IDLE and RUN.
REQ-014 subkey SHALL equal PC2(C||D) combinationally from registers, via the existing PC2 permutation block, so it changes only on clock edges.
REQ-015 In IDLE with start=1 at edge T: C||D <= PC1(key), then rotated for round 1; mode <= decrypt; round <= 0; state <= RUN; subkey_valid and busy high from T+1.
REQ-016 Left-shift table L[1..16] SHALL be 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
REQ-017 Encrypt: for round r, C and D SHALL each be rotated left by L[r] relative to round r-1; round 1 rotates PC1 output by 1.
REQ-018 Decrypt: round 1 SHALL use PC1 output unrotated; round r>=2 SHALL rotate C and D right by L[18-r].
REQ-019 C and D SHALL rotate independently; no bit crosses between halves.
REQ-020 Handshake: a transfer occurs on an edge where subkey_valid=1 and subkey_ready=1.
REQ-021 While subkey_valid=1 and subkey_ready=0, subkey, round, C, D SHALL hold stable indefinitely.
REQ-022 On transfer with round<15: apply next rotation, round increments, subkey_valid stays 1 (one subkey per cycle at full throughput).
REQ-023 On transfer with round=15: state <= IDLE, subkey_valid <= 0, busy <= 0, done <= 1 for exactly one cycle; C, D, round hold.
REQ-024 start SHALL be ignored while busy=1, including the cycle of the final transfer; a new sequence can be started no earlier than the cycle done is high.
REQ-025 subkey_ready while subkey_valid=0 SHALL have no effect.
REQ-026 Latency: first subkey valid 1 cycle after start; full sequence 17 cycles minimum from start to done.

Reset
REQ-027 With rst_n=0 at a clock edge: state <= IDLE; C, D, round, mode <= 0; subkey_valid, busy, done <= 0; subkey therefore reads 0.
REQ-028 Reset SHALL take priority over start and transfer on the same edge, and SHALL abort a sequence mid-operation with no done pulse.

Verification
REQ-029 key=133457799BBCDFF1, decrypt=0, subkey_ready held 1 -> K1=1B02EFFC7072 at T+1, K16=CB3D8B0E17F5 at T+16, done pulse at T+17.
REQ-030 Same key, decrypt=1 -> first subkey CB3D8B0E17F5 (round=0), last 1B02EFFC7072; all 16 match the encrypt sequence reversed.
REQ-031 Random subkey_ready backpressure -> subkey/round stable while stalled; exactly 16 transfers, matching a reference model, then one done.
REQ-032 start pulsed while busy with a different key -> ignored; sequence completes with the original key's subkeys.
REQ-033 rst_n=0 asserted at round 7 -> next cycle subkey_valid=0, busy=0, subkey=0, no done; new start then yields correct K1.
REQ-034 Key with parity bits flipped -> identical 16 subkeys to unmodified key.
